// File: rtl/product_assembler_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the product assembler:
//   - precision mode encodings (prec_e)
//   - assembler FSM state enum (state_e)
//   - per-mode partial-product count and per-index left-shift tables
//   - lane width for dual-lane mode
// ----------------------------------------------------------------------------
package mult_pkg;

    localparam int unsigned LANE_W = 16;

    typedef enum logic [1:0] {
        PREC_8X8   = 2'b00,
        PREC_DUAL  = 2'b01,
        PREC_16X16 = 2'b10,
        PREC_16X8  = 2'b11
    } prec_e;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FIX,
        OUT
    } state_e;

    // Number of partial products expected per mode, indexed by prec_e.
    localparam logic [2:0] PP_COUNT [4] = '{3'd1, 3'd2, 3'd4, 3'd2};

    // Left shift applied to each partial product, indexed [prec][pp index].
    // Dual-lane mode places pp1 into the upper lane with a 16-bit shift; the
    // lower 16 bits of that addend are zero, so no carry crosses the lanes.
    localparam logic [4:0] PP_SHIFT [4][4] = '{
        '{5'd0, 5'd0,  5'd0, 5'd0 },
        '{5'd0, 5'd16, 5'd0, 5'd0 },
        '{5'd0, 5'd8,  5'd8, 5'd16},
        '{5'd0, 5'd8,  5'd0, 5'd0 }
    };

    // True when idx is the index of the final partial product for mode p.
    function automatic logic is_last_pp(input prec_e p, input logic [1:0] idx);
        return ({1'b0, idx} == (PP_COUNT[p] - 3'd1));
    endfunction

endpackage

// File: rtl/product_assembler_if.sv
// ----------------------------------------------------------------------------
// product_assembler_if
// Handshake/data bundle between the multiplier-side producer and the
// product assembler.
//   start, prec, sa, sb      : operation request and mode/sign capture
//   pp_valid, pp, pp_ready   : partial-product stream
//   out_ready, res_valid,
//   res, res_neg             : result handshake
//   busy                     : assembler not in IDLE
// master = producer/consumer side, slave = assembler side.
// ----------------------------------------------------------------------------
interface product_assembler_if;

    logic        start;
    logic [1:0]  prec;
    logic        sa;
    logic        sb;
    logic        pp_valid;
    logic [15:0] pp;
    logic        pp_ready;
    logic        out_ready;
    logic        res_valid;
    logic [31:0] res;
    logic        res_neg;
    logic        busy;

    modport master (
        output start, prec, sa, sb, pp_valid, pp, out_ready,
        input  pp_ready, res_valid, res, res_neg, busy
    );

    modport slave (
        input  start, prec, sa, sb, pp_valid, pp, out_ready,
        output pp_ready, res_valid, res, res_neg, busy
    );

endinterface

// File: rtl/product_assembler_sign_fix.sv
// ----------------------------------------------------------------------------
// sign_fix
// Combinational lane-aware two's-complement negation.
//   i_value[31:0] : unsigned magnitude
//   i_neg         : apply negation
//   i_dual        : treat value as two independent 16-bit lanes
//   o_value[31:0] : signed result (per lane when i_dual)
//   o_is_neg      : negation applied to a non-zero magnitude (OR of lanes)
// ----------------------------------------------------------------------------
module sign_fix
    import mult_pkg::*;
(
    input  logic [31:0] i_value,
    input  logic        i_neg,
    input  logic        i_dual,
    output logic [31:0] o_value,
    output logic        o_is_neg
);

    logic [LANE_W-1:0] w_lo;
    logic [LANE_W-1:0] w_hi;
    logic [LANE_W-1:0] w_lo_neg;
    logic [LANE_W-1:0] w_hi_neg;
    logic [31:0]       w_full_neg;

    always_comb begin
        w_lo       = i_value[LANE_W-1:0];
        w_hi       = i_value[2*LANE_W-1:LANE_W];
        w_lo_neg   = '0 - w_lo;
        w_hi_neg   = '0 - w_hi;
        w_full_neg = '0 - i_value;

        o_value  = i_value;
        o_is_neg = 1'b0;

        if (i_neg) begin
            if (i_dual) begin
                o_value  = {w_hi_neg, w_lo_neg};
                o_is_neg = (w_lo != '0) || (w_hi != '0);
            end else begin
                o_value  = w_full_neg;
                o_is_neg = (i_value != '0);
            end
        end
    end

endmodule

// File: rtl/product_assembler.sv
// ----------------------------------------------------------------------------
// product_assembler
// Collects unsigned 8x8 partial products from a multiplier array, shifts and
// accumulates them according to the precision mode, applies the sign
// (sign-magnitude operands) and presents a registered two's-complement result.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : product_assembler_if.slave (start/prec/sa/sb capture, pp stream,
//          result handshake, busy)
// Flow: IDLE -start-> COLLECT -last pp-> FIX (1 cycle) -> OUT -out_ready-> IDLE
// ----------------------------------------------------------------------------
module product_assembler
    import mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    product_assembler_if.slave    bus
);

    state_e      r_state;
    state_e      w_next;

    prec_e       r_prec;
    logic        r_neg;
    logic [1:0]  r_idx;
    logic [31:0] r_acc;
    logic [31:0] r_res;
    logic        r_res_neg;
    logic        r_res_valid;

    logic        w_start;
    logic        w_accept;
    logic        w_last;
    logic        w_fix;
    logic        w_out_done;
    logic [31:0] w_addend;
    logic [31:0] w_fixed;
    logic        w_fixed_neg;
    logic        w_dual;

    assign w_last   = is_last_pp(r_prec, r_idx);
    assign w_addend = {16'b0, bus.pp} << PP_SHIFT[r_prec][r_idx];
    assign w_dual   = (r_prec == PREC_DUAL);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_accept   = 1'b0;
        w_fix      = 1'b0;
        w_out_done = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_start = 1'b1;
                    w_next  = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.pp_valid) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_next = FIX;
                    end
                end
            end
            FIX: begin
                w_fix  = 1'b1;
                w_next = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    w_out_done = 1'b1;
                    w_next     = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    sign_fix u_sign_fix (
        .i_value  (r_acc),
        .i_neg    (r_neg),
        .i_dual   (w_dual),
        .o_value  (w_fixed),
        .o_is_neg (w_fixed_neg)
    );

    // ------------------------------------------------------------------
    // Datapath: capture, accumulate, sign fix, result hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prec      <= PREC_8X8;
            r_neg       <= 1'b0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_res       <= '0;
            r_res_neg   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_start) begin
                r_prec <= prec_e'(bus.prec);
                r_neg  <= bus.sa ^ bus.sb;
                r_idx  <= '0;
                r_acc  <= '0;
            end
            if (w_accept) begin
                r_acc <= r_acc + w_addend;
                r_idx <= r_idx + 2'd1;
            end
            // The fixed value updates the accumulator and is loaded into the
            // result registers on the same edge, so OUT presents it at once.
            if (w_fix) begin
                r_acc       <= w_fixed;
                r_res       <= w_fixed;
                r_res_neg   <= w_fixed_neg;
                r_res_valid <= 1'b1;
            end
            if (w_out_done) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.pp_ready  = (r_state == COLLECT);
    assign bus.busy      = (r_state != IDLE);
    assign bus.res_valid = r_res_valid;
    assign bus.res       = r_res;
    assign bus.res_neg   = r_res_neg;

endmodule
